// File: rtl/recip_arbiter.sv
// recip_arbiter: round-robin sharing of one combinational single-precision
// reciprocal unit among NUM_REQ requesters, through a two-stage pipeline
// (S1 operand register -> reciprocal -> S2 result register).
//
// Reciprocal arithmetic: round-to-nearest-even, flush-to-zero. Subnormal
// inputs are treated as signed zero, so they return signed infinity.
// Results that would be subnormal are returned as signed zero. Any NaN input
// returns the canonical quiet NaN 0x7FC00000. A signed infinity input returns
// a signed zero.
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high. req_ready is one-hot or zero and depends combinationally on
// req_valid and rsp_ready. Requesters hold req_valid/req_data until they are
// accepted. rsp_* stay stable while rsp_valid && !rsp_ready.
module recip_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [1:0]            rsp_exc,
  output logic [CNT_W-1:0]      exc_count,
  output logic                  busy
);

  localparam logic [49:0] DIV_NUM = 50'd1 << 49;

  // Pipeline and arbitration state.
  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_data_q, s1_data_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_data_q, s2_data_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic [1:0]        s2_exc_q, s2_exc_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  exc_count_q, exc_count_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [31:0]       grant_data;
  logic              s2_can_load;
  logic              s1_can_load;
  logic              accept;

  logic [31:0]       rcp_data;
  logic [1:0]        rcp_exc;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) grant_data = req_data[32*i +: 32];
    end
  end

  // Pipeline flow control and the accept strobe.
  always_comb begin
    s2_can_load = !s2_valid_q || rsp_ready;
    s1_can_load = !s1_valid_q || s2_can_load;
    accept      = grant_found && s1_can_load && !rst;
    req_ready   = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Combinational reciprocal of the S1 operand plus its exception class.
  always_comb begin
    logic        sgn;
    logic [7:0]  expn;
    logic [22:0] man;
    logic [49:0] den;
    logic [24:0] quo;
    logic [23:0] rem;
    logic        rnd_up;
    sgn    = s1_data_q[31];
    expn   = s1_data_q[30:23];
    man    = s1_data_q[22:0];
    // 2^49 / {1,man} gives the 24-bit significand of 2/1.man plus guard and
    // round-position bits; the leading one (bit 25) is implicit.
    den    = {26'd0, 1'b1, man};
    quo    = 25'(DIV_NUM / den);
    rem    = 24'(DIV_NUM % den);
    rnd_up = quo[1] & (quo[0] | (rem != 24'd0) | quo[2]);
    rcp_data = '0;
    rcp_exc  = 2'b00;
    if (expn == 8'hFF) begin
      rcp_exc  = 2'b10;
      rcp_data = (man != 23'd0) ? 32'h7FC0_0000 : {sgn, 31'd0};
    end else if (expn == 8'd0) begin
      rcp_exc  = (man == 23'd0) ? 2'b01 : 2'b11;
      rcp_data = {sgn, 8'hFF, 23'd0};
    end else if (man == 23'd0) begin
      // Exact power of two; 2^-127 would be subnormal and flushes to zero.
      rcp_data = (expn == 8'd254) ? {sgn, 31'd0} : {sgn, 8'(8'd254 - expn), 23'd0};
    end else if (expn >= 8'd253) begin
      rcp_data = {sgn, 31'd0};
    end else begin
      // A rounding carry out of the mantissa ripples into the exponent.
      rcp_data = {sgn, 8'(8'd253 - expn), quo[24:2]} + {31'd0, rnd_up};
    end
  end

  // Next-state for S1, S2, the round-robin pointer and the exception counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_id_d     = s2_id_q;
    s2_exc_d    = s2_exc_q;
    rr_ptr_d    = rr_ptr_q;
    exc_count_d = exc_count_q;
    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = rcp_data;
        s2_id_d   = s1_id_q;
        s2_exc_d  = rcp_exc;
      end
    end
    if (s1_can_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = grant_data;
        s1_id_d   = grant_idx;
      end
    end
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
    if (s2_valid_q && rsp_ready && (s2_exc_q != 2'b00) && (exc_count_q != '1)) begin
      exc_count_d = exc_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; an op in flight is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_id_q     <= '0;
      s2_exc_q    <= '0;
      rr_ptr_q    <= '0;
      exc_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_id_q     <= s2_id_d;
      s2_exc_q    <= s2_exc_d;
      rr_ptr_q    <= rr_ptr_d;
      exc_count_q <= exc_count_d;
    end
  end

  // Output view of S2 and occupancy.
  always_comb begin
    rsp_valid = s2_valid_q;
    rsp_data  = s2_data_q;
    rsp_id    = s2_id_q;
    rsp_exc   = s2_exc_q;
    exc_count = exc_count_q;
    busy      = s1_valid_q | s2_valid_q;
  end

endmodule
